acc_lut_encoder: RTL and testbench

Reverse lookup for the accumulator constant table. Given an 8-bit constant, it finds the lowest 5-bit key whose table entry equals that constant. It scans the key space one key per cycle under a start/done handshake. The assembler-support and self-check logic use it to turn a required accumulator immediate back into the key the decoder expects, and to flag constants the table cannot produce.

---
 rtl/acc_lut_encoder.sv | 104 ++++++++++
 tb/tb_acc_lut_encoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/acc_lut_encoder.sv
// Reverse lookup of the accumulator constant table: finds the lowest key whose
// entry equals a given constant by scanning one key per cycle.
`timescale 1ns/1ps
module acc_lut_encoder #(
   parameter int KEY_W = 5,
   parameter int VAL_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             clear,
   input  logic [VAL_W-1:0] target,
   output logic             busy,
   output logic             done,
   output logic             hit,
   output logic [KEY_W-1:0] key
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [KEY_W-1:0] LAST_KEY = {KEY_W{1'b1}};

   state_t           state_q, state_d;
   logic [KEY_W-1:0] idx_q, idx_d;
   logic [VAL_W-1:0] tgt_q, tgt_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic             hit_q, hit_d;

   // Must stay bit-identical to the decoder's table.
   function automatic logic [VAL_W-1:0] table_at(input logic [KEY_W-1:0] k);
      case (k)
         KEY_W'(0): table_at = VAL_W'(255);
         KEY_W'(1): table_at = VAL_W'(63);
         KEY_W'(2): table_at = VAL_W'(0);
         KEY_W'(3): table_at = VAL_W'(1);
         KEY_W'(4): table_at = VAL_W'(64);
         KEY_W'(5): table_at = VAL_W'(65);
         default:   table_at = VAL_W'(0);
      endcase
   endfunction

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      idx_d   = idx_q;
      tgt_d   = tgt_q;
      key_d   = key_q;
      hit_d   = hit_q;
      if (clear) begin
         state_d = IDLE;
         idx_d   = '0;
         key_d   = '0;
         hit_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               tgt_d   = target;
               idx_d   = '0;
               key_d   = '0;
               hit_d   = 1'b0;
               state_d = SCAN;
            end
            SCAN: begin
               if (table_at(idx_q) == tgt_q) begin
                  key_d   = idx_q;
                  hit_d   = 1'b1;
                  state_d = DONE;
               end else if (idx_q == LAST_KEY) begin
                  key_d   = '0;
                  hit_d   = 1'b0;
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         tgt_q   <= '0;
         key_q   <= '0;
         hit_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking so all registers update together from pre-edge values.
         state_q <= state_d;
         idx_q   <= idx_d;
         tgt_q   <= tgt_d;
         key_q   <= key_d;
         hit_q   <= hit_d;
      end
   end

   assign busy = (state_q == SCAN);
   assign done = (state_q == DONE);
   assign hit  = hit_q;
   assign key  = key_q;

endmodule

// File: tb/tb_acc_lut_encoder.sv
// Directed bench for acc_lut_encoder: stimulus queues expected results, a
// monitor pops and compares on every done pulse (result and latency).
`timescale 1ns/1ps
module tb_acc_lut_encoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] target = 8'h00;
   logic       busy, done, hit;
   logic [4:0] key;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic prev_done = 1'b0;
   int   bc;

   typedef struct {
      logic       hit;
      logic [4:0] key;
      int         cyc;
   } exp_t;

   exp_t sb[$];

   acc_lut_encoder #(.KEY_W(5), .VAL_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .target(target),
      .busy(busy), .done(done), .hit(hit), .key(key)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Issue a start sampled at the next edge E0; returns at the negedge after E0.
   // Done for key k is expected at the negedge after E(k+1), a miss after E32.
   task automatic do_start(input logic [7:0] t, input bit expect_it,
                           input logic exp_hit, input int exp_key);
      exp_t e;
      @(negedge clk);
      start  = 1'b1;
      target = t;
      if (expect_it) begin
         e.hit = exp_hit;
         e.key = 5'(exp_key);
         e.cyc = cyc + (exp_hit ? exp_key + 2 : 33);
         sb.push_back(e);
      end
      @(negedge clk);
      start  = 1'b0;
      target = 8'h5A;
   endtask

   task automatic wait_done(input string name, output int busy_cycles);
      bit seen;
      seen = 1'b0;
      busy_cycles = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (done) seen = 1'b1;
         else begin
            if (busy) busy_cycles++;
            @(negedge clk);
         end
      end
      check({"timeout_", name}, 32'(seen), 32'd1);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (done) begin
            check("done_width", 32'(prev_done), 32'd0);
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("hit", 32'(hit), 32'(e.hit));
               check("key", 32'(key), 32'(e.key));
               check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
         end
         prev_done = done;
      end
   end

   initial begin : stim
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_hit",  32'(hit),  32'd0);
      check("rst_key",  32'(key),  32'd0);
      rst_n = 1'b1;

      do_start(8'hFF, 1'b1, 1'b1, 0);
      wait_done("ff", bc);
      do_start(8'd65, 1'b1, 1'b1, 5);
      wait_done("k5", bc);
      check("k5_busy_cycles", 32'(bc), 32'd6);
      repeat (3) @(negedge clk);
      check("hold_hit",  32'(hit),  32'd1);
      check("hold_key",  32'(key),  32'd5);
      check("idle_busy", 32'(busy), 32'd0);

      do_start(8'd0, 1'b1, 1'b1, 2);
      wait_done("zero", bc);

      do_start(8'd7, 1'b1, 1'b0, 0);
      wait_done("miss", bc);
      check("miss_busy_cycles", 32'(bc), 32'd32);

      // Second start at E2 while scanning must be ignored.
      do_start(8'd64, 1'b1, 1'b1, 4);
      @(negedge clk);
      start  = 1'b1;
      target = 8'hFF;
      @(negedge clk);
      start  = 1'b0;
      wait_done("ignored_start", bc);
      repeat (40) @(negedge clk);

      // Clear sampled at E10 aborts the scan with no done.
      do_start(8'd7, 1'b0, 1'b0, 0);
      repeat (9) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clr_busy", 32'(busy), 32'd0);
      check("clr_done", 32'(done), 32'd0);
      check("clr_hit",  32'(hit),  32'd0);
      check("clr_key",  32'(key),  32'd0);
      repeat (40) @(negedge clk);

      do_start(8'd1, 1'b1, 1'b1, 3);
      wait_done("k3", bc);

      // Clear beats start in IDLE and wipes the held result.
      @(negedge clk);
      start  = 1'b1;
      clear  = 1'b1;
      target = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      clear = 1'b0;
      check("clrstart_busy", 32'(busy), 32'd0);
      check("clrstart_hit",  32'(hit),  32'd0);
      check("clrstart_key",  32'(key),  32'd0);
      repeat (3) @(negedge clk);
      check("clrstart_still_idle", 32'(busy), 32'd0);

      // Asynchronous reset between E20 and E21 of a miss scan.
      do_start(8'd7, 1'b0, 1'b0, 0);
      repeat (20) @(negedge clk);
      check("pre_rst_busy", 32'(busy), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_hit",  32'(hit),  32'd0);
      check("arst_key",  32'(key),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);

      do_start(8'd63, 1'b1, 1'b1, 1);
      wait_done("k1", bc);
      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
